mem_align_rmw: RTL and testbench

Data-memory access unit between the MIPS datapath load/store path and a word-only data memory. It accepts byte, halfword and word load/store requests and produces word-aligned memory transactions. Loads return the lane extracted from the fetched word, sign- or zero-extended to 32 bits. Sub-word stores run as a read-modify-write sequence, because the memory has no byte enables.

---
 rtl/mem_align_rmw.sv | 165 ++++++++++++++++
 tb/tb_mem_align_rmw.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_align_rmw.sv
// Load/store alignment unit: maps byte/half/word requests onto a word-only memory,
// extracting and extending load lanes and running read-modify-write for sub-word stores.
module mem_align_rmw #(
  parameter int ADDRWIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [1:0]           req_size,
  input  logic                 req_signext,
  input  logic [ADDRWIDTH-1:0] req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 resp_valid,
  output logic [31:0]          resp_rdata,
  output logic                 resp_err,
  output logic                 mem_valid,
  output logic                 mem_we,
  output logic [ADDRWIDTH-1:0] mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic                 mem_ready,
  input  logic [31:0]          mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t      r_state;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_signext;
  logic [1:0]  r_off;
  logic [15:0] r_lane;

  logic        w_err;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_merge;

  always_comb begin
    w_err = (req_size == 2'b11) ||
            (req_size == SZ_HALF && req_addr[0]) ||
            (req_size == SZ_WORD && req_addr[1:0] != 2'b00);
  end

  // Big-endian lanes: offset 0 is the most significant byte of the word.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    w_byte = mem_rdata[7:0];
    w_half = r_off[1] ? mem_rdata[15:0] : mem_rdata[31:16];
    case (r_off)
      2'd0:    w_byte = mem_rdata[31:24];
      2'd1:    w_byte = mem_rdata[23:16];
      2'd2:    w_byte = mem_rdata[15:8];
      default: w_byte = mem_rdata[7:0];
    endcase
    case (r_size)
      SZ_BYTE: w_load = r_signext ? {{24{w_byte[7]}}, w_byte} : {24'b0, w_byte};
      SZ_HALF: w_load = r_signext ? {{16{w_half[15]}}, w_half} : {16'b0, w_half};
      default: w_load = mem_rdata;
    endcase
  end

  always_comb begin
    w_merge = mem_rdata;
    if (r_size == SZ_BYTE) begin
      case (r_off)
        2'd0:    w_merge[31:24] = r_lane[7:0];
        2'd1:    w_merge[23:16] = r_lane[7:0];
        2'd2:    w_merge[15:8]  = r_lane[7:0];
        default: w_merge[7:0]   = r_lane[7:0];
      endcase
    end else if (r_off[1]) begin
      w_merge[15:0] = r_lane;
    end else begin
      w_merge[31:16] = r_lane;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_we       <= 1'b0;
      r_size     <= 2'b00;
      r_signext  <= 1'b0;
      r_off      <= 2'b00;
      r_lane     <= 16'b0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'b0;
      resp_err   <= 1'b0;
      mem_valid  <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 32'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            r_we      <= req_we;
            r_size    <= req_size;
            r_signext <= req_signext;
            r_off     <= req_addr[1:0];
            r_lane    <= req_wdata[15:0];
            if (w_err) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'b0;
              r_state    <= S_RESP;
            end else begin
              mem_valid <= 1'b1;
              mem_addr  <= {req_addr[ADDRWIDTH-1:2], 2'b00};
              if (req_we && req_size == SZ_WORD) begin
                mem_we    <= 1'b1;
                mem_wdata <= req_wdata;
                r_state   <= S_WR;
              end else begin
                mem_we  <= 1'b0;
                r_state <= S_RD;
              end
            end
          end
        end
        S_RD: begin
          if (mem_ready) begin
            if (r_we) begin
              mem_we    <= 1'b1;
              mem_wdata <= w_merge;
              r_state   <= S_WR;
            end else begin
              mem_valid  <= 1'b0;
              resp_valid <= 1'b1;
              resp_rdata <= w_load;
              r_state    <= S_RESP;
            end
          end
        end
        S_WR: begin
          if (mem_ready) begin
            mem_valid  <= 1'b0;
            mem_we     <= 1'b0;
            resp_valid <= 1'b1;
            resp_rdata <= 32'b0;
            r_state    <= S_RESP;
          end
        end
        default: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= 32'b0;
          req_ready  <= 1'b1;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_align_rmw.sv
// Self-checking bench for mem_align_rmw: directed plan plus random traffic against a
// behavioural memory and an arithmetic lane model.
module tb_mem_align_rmw;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signext;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  mem_align_rmw #(.ADDRWIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signext(req_signext),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_valid  (mem_valid),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Behavioural word memory; unwritten words return an address-derived pattern.
  logic [31:0] mem [logic [31:0]];
  function automatic logic [31:0] mem_peek(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], ~a[15:0]};
  endfunction

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t log_q[$];
  int   stall_cnt;
  logic prev_stall = 1'b0;
  txn_t snap;
  bit   ready_q[$];
  bit   pend_q[$];
  bit   rand_ready = 1'b0;
  logic rdy;

  assign mem_ready = rdy;

  always @(negedge clk) begin
    mem_rdata = mem_peek(mem_addr);
    if (ready_q.size() > 0) rdy = ready_q.pop_front();
    else if (rand_ready)    rdy = ($urandom_range(0, 3) != 0);
    else                    rdy = 1'b1;
  end

  always @(posedge clk) begin
    if (reset) begin
      if (prev_stall && mem_valid) begin
        check("hold_we", 32'(mem_we), 32'(snap.we));
        check("hold_addr", mem_addr, snap.addr);
        check("hold_wdata", mem_wdata, snap.data);
      end
      if (mem_valid) check("addr_align", 32'(mem_addr[1:0]), 32'd0);
      prev_stall = mem_valid && !mem_ready;
      if (prev_stall) begin
        stall_cnt++;
        snap = '{mem_we, mem_addr, mem_wdata};
      end
      if (mem_valid && mem_ready) begin
        log_q.push_back('{mem_we, mem_addr, mem_wdata});
        if (mem_we) mem[mem_addr] = mem_wdata;
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Reference: lane position and width as shift/mask arithmetic over the whole word.
  function automatic void ref_model(input logic we, input logic [1:0] size, input logic sx,
                                    input logic [31:0] addr, input logic [31:0] wdata,
                                    input logic [31:0] word, output logic err,
                                    output logic [31:0] rdata, output logic [31:0] new_word,
                                    output int lat);
    int          sh;
    logic [31:0] m;
    logic [31:0] v;
    err      = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
    rdata    = 32'd0;
    new_word = word;
    lat      = 1;
    if (err) return;
    if (size == 2'd0) begin
      sh = 8 * (3 - int'(addr[1:0]));
      m  = 32'h0000_00FF;
    end else if (size == 2'd1) begin
      sh = 16 * (1 - int'(addr[1]));
      m  = 32'h0000_FFFF;
    end else begin
      sh = 0;
      m  = 32'hFFFF_FFFF;
    end
    if (!we) begin
      v = (word >> sh) & m;
      if (sx && size != 2'd2 && ((v & ((m >> 1) + 32'd1)) != 32'd0)) v = v | ~m;
      rdata = v;
      lat   = 2;
    end else begin
      new_word = (word & ~(m << sh)) | ((wdata & m) << sh);
      lat      = (size == 2'd2) ? 2 : 3;
    end
  endfunction

  task automatic do_req(input logic we, input logic [1:0] size, input logic sx,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input string tag, output int lat);
    logic [31:0] word_a;
    logic [31:0] exp_rdata;
    logic [31:0] exp_word;
    logic        exp_err;
    int          base_lat;
    int          w;
    txn_t        exp_q[$];
    word_a = {addr[31:2], 2'b00};
    ref_model(we, size, sx, addr, wdata, mem_peek(word_a), exp_err, exp_rdata, exp_word, base_lat);
    if (!exp_err) begin
      if (!we || size != 2'd2) exp_q.push_back('{1'b0, word_a, 32'd0});
      if (we) exp_q.push_back('{1'b1, word_a, exp_word});
    end
    @(negedge clk);
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_ready_idle"}, 32'(req_ready), 32'd1);
    req_valid   = 1'b1;
    req_we      = we;
    req_size    = size;
    req_signext = sx;
    req_addr    = addr;
    req_wdata   = wdata;
    @(posedge clk);
    log_q.delete();
    stall_cnt = 0;
    ready_q   = pend_q;
    pend_q.delete();
    @(negedge clk);
    req_valid   = 1'b0;
    req_we      = 1'($urandom);
    req_size    = 2'($urandom);
    req_signext = 1'($urandom);
    req_addr    = $urandom;
    req_wdata   = $urandom;
    check({tag, "_ready_busy"}, 32'(req_ready), 32'd0);
    lat = 1;
    while (!resp_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_resp_seen"}, 32'(resp_valid), 32'd1);
    check({tag, "_rdata"}, resp_rdata, exp_rdata);
    check({tag, "_err"}, 32'(resp_err), 32'(exp_err));
    check({tag, "_latency"}, 32'(lat), 32'(base_lat + stall_cnt));
    check({tag, "_ntxn"}, 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      check({tag, "_txn_we"}, 32'(log_q[i].we), 32'(exp_q[i].we));
      check({tag, "_txn_addr"}, log_q[i].addr, exp_q[i].addr);
      if (exp_q[i].we) check({tag, "_txn_wdata"}, log_q[i].data, exp_q[i].data);
    end
    @(negedge clk);
    check({tag, "_pulse"}, 32'(resp_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(req_ready), 32'd1);
    check({tag, "_memword"}, mem_peek(word_a), exp_word);
  endtask

  initial begin
    int lat;
    int w;
    reset       = 1'b0;
    req_valid   = 1'b0;
    req_we      = 1'b0;
    req_size    = 2'b00;
    req_signext = 1'b0;
    req_addr    = 32'd0;
    req_wdata   = 32'd0;
    rdy         = 1'b1;
    #12;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    mem[32'h100] = 32'h80FF_7F01;
    do_req(1'b0, 2'd0, 1'b1, 32'h101, 32'h0, "lb", lat);
    check("lb_value", resp_rdata, 32'h0);
    do_req(1'b0, 2'd0, 1'b0, 32'h100, 32'h0, "lbu", lat);
    do_req(1'b0, 2'd1, 1'b1, 32'h100, 32'h0, "lh", lat);
    do_req(1'b0, 2'd1, 1'b0, 32'h102, 32'h0, "lhu", lat);
    do_req(1'b0, 2'd2, 1'b1, 32'h100, 32'h0, "lw", lat);
    check("lw_latency_abs", 32'(lat), 32'd2);

    mem[32'h200] = 32'h1122_3344;
    do_req(1'b1, 2'd0, 1'b0, 32'h203, 32'h0000_00AA, "sb3", lat);
    check("sb3_word_abs", mem_peek(32'h200), 32'h1122_33AA);
    check("sb3_latency_abs", 32'(lat), 32'd3);
    mem[32'h200] = 32'h1122_3344;
    do_req(1'b1, 2'd0, 1'b0, 32'h200, 32'h0000_00BB, "sb0", lat);
    check("sb0_word_abs", mem_peek(32'h200), 32'hBB22_3344);
    mem[32'h200] = 32'h1122_3344;
    do_req(1'b1, 2'd1, 1'b0, 32'h202, 32'h0000_CAFE, "sh2", lat);
    check("sh2_word_abs", mem_peek(32'h200), 32'h1122_CAFE);
    do_req(1'b1, 2'd2, 1'b0, 32'h204, 32'hDEAD_BEEF, "sw", lat);
    check("sw_word_abs", mem_peek(32'h204), 32'hDEAD_BEEF);

    do_req(1'b0, 2'd1, 1'b1, 32'h101, 32'h0, "err_lh", lat);
    check("err_lh_flag_abs", 32'(lat), 32'd1);
    do_req(1'b1, 2'd2, 1'b0, 32'h206, 32'h1234_5678, "err_sw", lat);
    do_req(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, "err_sz", lat);

    mem[32'h200] = 32'h1122_3344;
    pend_q = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    do_req(1'b1, 2'd0, 1'b0, 32'h203, 32'h0000_00AA, "sb_wait", lat);
    check("sb_wait_latency_abs", 32'(lat), 32'd9);

    rand_ready = 1'b1;
    for (int i = 0; i < 150; i++) begin
      logic [1:0] sz;
      sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      do_req(1'($urandom), sz, 1'($urandom), 32'h300 + 32'($urandom_range(0, 63)),
             $urandom, "rnd", lat);
    end
    rand_ready = 1'b0;

    // Abort a sub-word store while its write is stalled.
    mem[32'h200] = 32'h1122_3344;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'd0;
    req_addr  = 32'h201;
    req_wdata = 32'h0000_0055;
    @(posedge clk);
    ready_q = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    @(negedge clk);
    req_valid = 1'b0;
    w = 0;
    while (!(mem_valid && mem_we) && w < 10) begin
      @(negedge clk);
      w++;
    end
    check("abort_in_wr", 32'(mem_valid && mem_we), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("abort_mem_valid", 32'(mem_valid), 32'd0);
    check("abort_req_ready", 32'(req_ready), 32'd1);
    check("abort_resp_valid", 32'(resp_valid), 32'd0);
    check("abort_mem_addr", mem_addr, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    ready_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_resp", 32'(resp_valid), 32'd0);
    end
    check("abort_mem_unchanged", mem_peek(32'h200), 32'h1122_3344);
    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, "post_rst_lw", lat);
    check("post_rst_lw_abs", resp_rdata, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
